// File: rtl/bf_uart_pkg.sv
// Shared types and helpers for the buffered BF UART transmitter.
// Optional even parity bit is enabled by defining BF_UART_PARITY_EN.
package bf_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int FRAME_DATA_BITS = 8;

   // Clocks per bit time; the fractional part is dropped.
   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/bf_sync_fifo.sv
// Small single-clock FIFO with combinational read of the head entry.
// A push while full is accepted only when a pop happens in the same cycle.
module bf_sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [DEPTH_LOG2:0]   count_reg;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == DEPTH_CNT);
   assign count   = count_reg;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   // Pointer widths make the wrap modulo DEPTH implicit.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/bf_uart_tx_queue.sv
// Buffered 8N1 UART transmitter fed by rising edges of the BF core output strobe.
// Define BF_UART_PARITY_EN to insert an even parity bit (8E1 frame).
module bf_uart_tx_queue
   import bf_uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] char,
   input  logic       valid,
   output logic       uart_tx,
   output logic       busy,
   output logic       full,
   output logic       overflow
);

   localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
   localparam int CNT_W    = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [2:0]       LAST_BIT  = 3'(FRAME_DATA_BITS - 1);

   tx_state_t           state_reg;
   logic [CNT_W-1:0]    baud_cnt_reg;
   logic [2:0]          bit_idx_reg;
   logic [7:0]          sr_reg;
   logic                tx_reg;
   logic                overflow_reg;
   logic                valid_q_reg;
`ifdef BF_UART_PARITY_EN
   logic                parity_reg;
`endif

   logic                push;
   logic                pop;
   logic                baud_end;
   logic [7:0]          fifo_rdata;
   logic [DEPTH_LOG2:0] fifo_count;
   logic                fifo_full;
   logic                fifo_empty;

   assign push     = valid & ~valid_q_reg;
   assign baud_end = (baud_cnt_reg == BAUD_LAST);
   // Dequeue only when the line is free or a stop bit is just finishing.
   assign pop      = ~fifo_empty &
                     ((state_reg == IDLE) || ((state_reg == STOP) && baud_end));

   bf_sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (push),
      .pop   (pop),
      .wdata (char),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign uart_tx  = tx_reg;
   assign busy     = (state_reg != IDLE) | (fifo_count != '0);
   assign full     = fifo_full;
   assign overflow = overflow_reg;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         sr_reg       <= '0;
         tx_reg       <= 1'b1;
         overflow_reg <= 1'b0;
         valid_q_reg  <= 1'b0;
`ifdef BF_UART_PARITY_EN
         parity_reg   <= 1'b0;
`endif
      end else begin
         valid_q_reg <= valid;
         if (push && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               baud_cnt_reg <= '0;
               tx_reg       <= 1'b1;
               if (pop) begin
                  sr_reg    <= fifo_rdata;
`ifdef BF_UART_PARITY_EN
                  parity_reg <= ^fifo_rdata;
`endif
                  tx_reg    <= 1'b0;
                  state_reg <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_cnt_reg <= '0;
                  bit_idx_reg  <= '0;
                  tx_reg       <= sr_reg[0];
                  state_reg    <= DATA;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt_reg <= '0;
                  if (bit_idx_reg == LAST_BIT) begin
`ifdef BF_UART_PARITY_EN
                     tx_reg    <= parity_reg;
                     state_reg <= PARITY;
`else
                     tx_reg    <= 1'b1;
                     state_reg <= STOP;
`endif
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                     sr_reg      <= sr_reg >> 1;
                     tx_reg      <= sr_reg[1];
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end
`ifdef BF_UART_PARITY_EN
            PARITY: begin
               if (baud_end) begin
                  baud_cnt_reg <= '0;
                  tx_reg       <= 1'b1;
                  state_reg    <= STOP;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end
`endif
            STOP: begin
               if (baud_end) begin
                  baud_cnt_reg <= '0;
                  // Chain straight into the next start bit when more bytes wait.
                  if (pop) begin
                     sr_reg    <= fifo_rdata;
`ifdef BF_UART_PARITY_EN
                     parity_reg <= ^fifo_rdata;
`endif
                     tx_reg    <= 1'b0;
                     state_reg <= START;
                  end else begin
                     tx_reg    <= 1'b1;
                     state_reg <= IDLE;
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end
            default: begin
               baud_cnt_reg <= '0;
               tx_reg       <= 1'b1;
               state_reg    <= IDLE;
            end
         endcase
      end
   end

endmodule
